uart_tx_controller: RTL and testbench

- Sequences one serial UART transmit frame per accepted write: start bit, 8 data bits LSB-first, even parity bit, stop bit.
- Bit timing comes from the baud tick `sample_ENABLE`, produced by the baud controller at 16x the bit rate. One bit lasts 16 ticks.
- Sits between the host write interface and the `Tx_D` line.
- Owns all framing state and handshake signalling. The baud controller owns the rate selection.

---
 rtl/uart_tx_controller.sv | 96 +++++++++
 tb/tb_uart_tx_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB-first, even parity, stop bit.
// Bit timing is taken from the 16x baud tick sample_ENABLE.
module uart_tx_controller #(
  parameter int TICKS_PER_BIT = 16,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 Tx_D,
  output logic                 Tx_BUSY,
  output logic                 Tx_DONE
);

  localparam int CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 parity;
  logic                 accept, bit_end;
  logic                 tx_d_next, busy_next, done_next;

  // The cycle Tx_DONE is high still counts as the end of the previous frame.
  assign accept  = (state == IDLE) && !Tx_DONE && Tx_WR && Tx_EN;
  assign bit_end = sample_ENABLE && (tick_cnt == CNT_W'(TICKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      Tx_D     <= 1'b1;
      Tx_BUSY  <= 1'b0;
      Tx_DONE  <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      Tx_D    <= tx_d_next;
      Tx_BUSY <= busy_next;
      Tx_DONE <= done_next;
      if (accept) begin
        parity   <= ^Tx_DATA;
        tick_cnt <= '0;
        bit_idx  <= '0;
      end else if (state != IDLE && sample_ENABLE) begin
        // Power-of-two tick count lets the counter wrap on its own at bit end.
        tick_cnt <= tick_cnt + CNT_W'(1);
        if (bit_end && state == DATA)
          bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == IDX_W'(DATA_BITS - 1)) state_next = PARITY;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and next shift value.
  always_comb begin
    shift_next = shift;
    if (accept)
      shift_next = Tx_DATA;
    else if (state == DATA && bit_end)
      shift_next = shift >> 1;

    tx_d_next = 1'b1;
    case (state_next)
      START:   tx_d_next = 1'b0;
      DATA:    tx_d_next = shift_next[0];
      PARITY:  tx_d_next = parity;
      default: tx_d_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && bit_end;
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: drives writes and baud ticks, compares line and handshake
// against a frame-level model that indexes an 11-bit frame by ticks elapsed since acceptance.
module tb_uart_tx_controller;
  localparam int TPB = 16;
  localparam int FRAME_TICKS = 11 * TPB;

  logic       clk = 1'b0;
  logic       reset, sample_ENABLE, Tx_EN, Tx_WR;
  logic [7:0] Tx_DATA;
  logic       Tx_D, Tx_BUSY, Tx_DONE;

  uart_tx_controller dut (
    .clk(clk), .reset(reset), .sample_ENABLE(sample_ENABLE), .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .Tx_D(Tx_D), .Tx_BUSY(Tx_BUSY), .Tx_DONE(Tx_DONE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is {stop, parity, data, start}; bit n is on the line for ticks 16n..16n+15.
  bit          m_active = 0;
  logic [10:0] m_frame = '1;
  int          m_ticks = 0;
  logic        exp_d = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

  task automatic cyc(input logic r, input logic wr, input logic en, input logic [7:0] d,
                     input logic tk);
    logic prev_done;
    reset = r; Tx_WR = wr; Tx_EN = en; Tx_DATA = d; sample_ENABLE = tk;
    @(posedge clk); #1;
    prev_done = exp_done;
    exp_done  = 1'b0;
    if (r) begin
      m_active = 0; m_ticks = 0;
    end else if (m_active) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == FRAME_TICKS) begin m_active = 0; exp_done = 1'b1; end
      end
    end else if (wr && en && !prev_done) begin
      m_active = 1; m_ticks = 0; m_frame = {1'b1, ^d, d, 1'b0};
    end
    exp_busy = m_active;
    exp_d    = m_active ? m_frame[m_ticks / TPB] : 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 503; k++) begin
      cyc(k < 3, 1'b0, 1'b0, 8'h00, 1'(($urandom_range(0, 3) == 0)));
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== 3'b100) begin
        errors++;
        if (errors <= 20) $display("FAIL reset_idle k=%0d got d/busy/done=%b%b%b want 100", k, Tx_D, Tx_BUSY, Tx_DONE);
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [10:0] seq = 11'b1_0_10100101_0;
    int busy_cnt = 0, done_cnt = 0;
    for (int k = 0; k < 720; k++) begin
      cyc(1'b0, k == 0, 1'b1, 8'hA5, 1'(k % 4 == 0));
      busy_cnt += int'(Tx_BUSY); done_cnt += int'(Tx_DONE);
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL frame_a5 k=%0d got %b%b%b want %b%b%b", k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
      end
      if (k % 64 == 32 && k < 704) begin
        checks++;
        if (Tx_D !== seq[k / 64]) begin
          errors++;
          $display("FAIL a5_bit%0d got %b want %b", k / 64, Tx_D, seq[k / 64]);
        end
      end
    end
    checks++;
    if (busy_cnt !== 704) begin errors++; $display("FAIL a5_busy_len got %0d want 704", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL a5_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2] = '{8'h07, 8'h00};
    logic       pars [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 370; k++) begin
        cyc(1'b0, k == 0, 1'b1, vals[v], 1'(k % 2 == 0));
        checks++;
        if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
          errors++;
          if (errors <= 20) $display("FAIL parity_frame v=%0d k=%0d got %b%b%b want %b%b%b", v, k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
        end
        if (k == 2 * (9 * TPB + 8)) begin
          checks++;
          if (Tx_D !== pars[v]) begin errors++; $display("FAIL parity_bit v=%0d got %b want %b", v, Tx_D, pars[v]); end
        end
        if (k == 2 * (10 * TPB + 8)) begin
          checks++;
          if (Tx_D !== 1'b1) begin errors++; $display("FAIL stop_bit v=%0d got %b want 1", v, Tx_D); end
        end
        if (v == 1 && k % (2 * TPB) == TPB && k > 2 * TPB && k < 2 * 9 * TPB) begin
          checks++;
          if (Tx_D !== 1'b0) begin errors++; $display("FAIL zero_data k=%0d got %b want 0", k, Tx_D); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_at = -1, done_cnt = 0;
    for (int k = 0; k < 1200; k++) begin
      logic       wr = (k == 0) || (k == 150) || (done_at >= 0 && k == done_at + 2);
      logic [7:0] d  = (k == 0) ? 8'hFF : 8'h3C;
      cyc(1'b0, wr, 1'b1, d, 1'(k % 2 == 1));
      if (exp_done && done_at < 0) done_at = k;
      done_cnt += int'(Tx_DONE);
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL back_to_back k=%0d got %b%b%b want %b%b%b", k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
      end
    end
    checks++;
    if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
  endtask

  task automatic test_enable();
    int done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1'b0, k == 0, 1'b0, 8'h5A, 1'(k % 3 == 0));
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== 3'b100) begin
        errors++;
        if (errors <= 20) $display("FAIL en_low_write k=%0d got %b%b%b want 100", k, Tx_D, Tx_BUSY, Tx_DONE);
      end
    end
    for (int k = 0; k < 560; k++) begin
      cyc(1'b0, k == 0, 1'(k < 200), 8'h55, 1'(k % 3 == 1));
      done_cnt += int'(Tx_DONE);
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL en_drop k=%0d got %b%b%b want %b%b%b", k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL en_drop_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    for (int k = 0; k < 1020; k++) begin
      logic       wr = (k == 0) || (k == 290);
      logic [7:0] d  = (k == 0) ? 8'hC6 : 8'h81;
      cyc(k == 280, wr, 1'b1, d, 1'(k % 4 == 0));
      done_cnt += int'(Tx_DONE);
      if (k == 280) begin
        checks++;
        if ({Tx_D, Tx_BUSY, Tx_DONE} !== 3'b100) begin
          errors++;
          $display("FAIL reset_mid got %b%b%b want 100", Tx_D, Tx_BUSY, Tx_DONE);
        end
      end
      checks++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL reset_then_81 k=%0d got %b%b%b want %b%b%b", k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL reset_mid_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [7:0] d = 8'($urandom);
      int         tail = -1;
      int         k = 0;
      while (tail != 0 && k < 4000) begin
        logic wr = (k == 0) || (m_active && $urandom_range(0, 49) == 0);
        logic en = (k == 0) || 1'($urandom_range(0, 1));
        cyc(1'b0, wr, en, (k == 0) ? d : 8'($urandom), 1'($urandom_range(0, 2) == 0));
        checks++;
        if ({Tx_D, Tx_BUSY, Tx_DONE} !== {exp_d, exp_busy, exp_done}) begin
          errors++;
          if (errors <= 20) $display("FAIL random f=%0d k=%0d got %b%b%b want %b%b%b", f, k, Tx_D, Tx_BUSY, Tx_DONE, exp_d, exp_busy, exp_done);
        end
        if (exp_done) tail = 3;
        else if (tail > 0) tail--;
        k++;
      end
      if (tail != 0) begin
        checks++; errors++;
        $display("FAIL random_timeout f=%0d got no completion want done within 4000 clk", f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
